// File: rtl/boot_load_controller.sv
// UART boot loader: sends 0x99, receives a big-endian size and that many program bytes,
// writes them as 32-bit big-endian words to program memory, sends 0xAA, then flags boot_done.
module boot_load_controller #(
  parameter int unsigned ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  output logic                  pm_wren,
  output logic [ADDR_WIDTH-1:0] pm_addr,
  output logic [31:0]           pm_wdata,
  output logic [31:0]           program_data_size,
  output logic                  boot_done
);

  typedef enum logic [2:0] {
    StIdle,
    StSend99,
    StRecvSize,
    StRecvData,
    StSendAa,
    StDone
  } state_e;

  state_e                state_q;
  logic [1:0]            size_cnt_q;
  logic [31:0]           byte_cnt_q;
  logic [31:0]           size_q;
  logic [31:0]           word_q;
  logic                  pm_wren_q;
  logic [ADDR_WIDTH-1:0] pm_addr_q;
  logic [31:0]           pm_wdata_q;

  logic [31:0] size_next;
  logic [31:0] word_next;
  logic [1:0]  lane;
  logic [4:0]  lane_shift;
  logic        last_byte;
  logic        word_full;

  always_comb begin
    size_next  = {size_q[23:0], rx_data};
    lane       = byte_cnt_q[1:0];
    // First byte of a word lands in [31:24]: shift by 8 * (3 - lane).
    lane_shift = {~lane, 3'b000};
    word_next  = word_q | ({24'd0, rx_data} << lane_shift);
    last_byte  = ((byte_cnt_q + 32'd1) == size_q);
    word_full  = (lane == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      size_cnt_q <= 2'd0;
      byte_cnt_q <= 32'd0;
      size_q     <= 32'd0;
      word_q     <= 32'd0;
      pm_wren_q  <= 1'b0;
      pm_addr_q  <= '0;
      pm_wdata_q <= 32'd0;
    end else begin
      pm_wren_q <= 1'b0;
      // Address advances on the edge that ends each write pulse.
      if (pm_wren_q) begin
        pm_addr_q <= pm_addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end
      case (state_q)
        StIdle: state_q <= StSend99;
        StSend99: begin
          if (tx_ready) state_q <= StRecvSize;
        end
        StRecvSize: begin
          if (rx_valid) begin
            size_q     <= size_next;
            size_cnt_q <= size_cnt_q + 2'd1;
            if (size_cnt_q == 2'd3) begin
              state_q <= (size_next == 32'd0) ? StSendAa : StRecvData;
            end
          end
        end
        StRecvData: begin
          if (rx_valid) begin
            byte_cnt_q <= byte_cnt_q + 32'd1;
            if (word_full || last_byte) begin
              pm_wren_q  <= 1'b1;
              pm_wdata_q <= word_next;
              word_q     <= 32'd0;
            end else begin
              word_q <= word_next;
            end
            if (last_byte) state_q <= StSendAa;
          end
        end
        StSendAa: begin
          if (tx_ready) state_q <= StDone;
        end
        StDone: state_q <= StDone;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    if (state_q == StSend99) begin
      tx_valid = 1'b1;
      tx_data  = 8'h99;
    end else if (state_q == StSendAa) begin
      tx_valid = 1'b1;
      tx_data  = 8'hAA;
    end
  end

  assign pm_wren           = pm_wren_q;
  assign pm_addr           = pm_addr_q;
  assign pm_wdata          = pm_wdata_q;
  assign program_data_size = size_q;
  assign boot_done         = (state_q == StDone);

endmodule

// File: tb/tb_boot_load_controller.sv
// Scoreboard bench: default-width and 2-bit-address instances share stimulus; a monitor
// pops expected tx bytes and memory writes whenever the DUTs present them.
module tb_boot_load_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_ready = 1'b1;

  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        pm_wren;
  logic [14:0] pm_addr;
  logic [31:0] pm_wdata;
  logic [31:0] program_data_size;
  logic        boot_done;

  logic        tx_valid_w;
  logic [7:0]  tx_data_w;
  logic        pm_wren_w;
  logic [1:0]  pm_addr_w;
  logic [31:0] pm_wdata_w;
  logic [31:0] program_data_size_w;
  logic        boot_done_w;

  boot_load_controller dut (
    .clk               (clk),
    .reset             (reset),
    .rx_valid          (rx_valid),
    .rx_data           (rx_data),
    .tx_ready          (tx_ready),
    .tx_valid          (tx_valid),
    .tx_data           (tx_data),
    .pm_wren           (pm_wren),
    .pm_addr           (pm_addr),
    .pm_wdata          (pm_wdata),
    .program_data_size (program_data_size),
    .boot_done         (boot_done)
  );

  boot_load_controller #(.ADDR_WIDTH(2)) dut_w (
    .clk               (clk),
    .reset             (reset),
    .rx_valid          (rx_valid),
    .rx_data           (rx_data),
    .tx_ready          (tx_ready),
    .tx_valid          (tx_valid_w),
    .tx_data           (tx_data_w),
    .pm_wren           (pm_wren_w),
    .pm_addr           (pm_addr_w),
    .pm_wdata          (pm_wdata_w),
    .program_data_size (program_data_size_w),
    .boot_done         (boot_done_w)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int          exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  int          expw_addr_q[$];
  logic [31:0] expw_data_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [7:0]  stim_bytes[$];
  logic [31:0] stim_words[$];
  logic [31:0] mem_w [4];
  int          next_addr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    int          a;
    logic [31:0] d;
    logic [7:0]  b;
    if (!reset && pm_wren) begin
      if (exp_addr_q.size() == 0) begin
        check("unexpected_write", 64'(pm_wren), 64'd0);
      end else begin
        a = exp_addr_q.pop_front();
        d = exp_data_q.pop_front();
        check("pm_addr", 64'(pm_addr), 64'(a[14:0]));
        check("pm_wdata", 64'(pm_wdata), 64'(d));
      end
    end
    if (!reset && pm_wren_w) begin
      mem_w[pm_addr_w] = pm_wdata_w;
      if (expw_addr_q.size() == 0) begin
        check("unexpected_write_w", 64'(pm_wren_w), 64'd0);
      end else begin
        a = expw_addr_q.pop_front();
        d = expw_data_q.pop_front();
        check("pm_addr_w", 64'(pm_addr_w), 64'(a[1:0]));
        check("pm_wdata_w", 64'(pm_wdata_w), 64'(d));
      end
    end
    if (!reset && tx_valid && tx_ready) begin
      if (exp_tx_q.size() == 0) begin
        check("unexpected_tx", 64'(tx_valid), 64'd0);
      end else begin
        b = exp_tx_q.pop_front();
        check("tx_data", 64'(tx_data), 64'(b));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    tick();
    @(negedge clk);
    check("reset_outputs", 64'({tx_valid, tx_data, pm_wren, pm_addr, pm_wdata, boot_done}), 64'd0);
    check("reset_size", 64'(program_data_size), 64'd0);
    check("reset_addr_w", 64'({pm_wren_w, pm_addr_w, boot_done_w}), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    next_addr = 0;
    @(negedge clk);
    check("idle_tx_valid", 64'(tx_valid), 64'd0);
  endtask

  task automatic wait_tx(input logic [7:0] b, input string name);
    int n;
    exp_tx_q.push_back(b);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (tx_valid && tx_ready) break;
      n++;
    end
    if (n == 100) check(name, 64'({tx_valid, tx_ready}), 64'd3);
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_addr_q.push_back(next_addr);
    exp_data_q.push_back(w);
    expw_addr_q.push_back(next_addr);
    expw_data_q.push_back(w);
    next_addr++;
  endtask

  // Full load of stim_bytes / stim_words; optionally skips the 0x99 handshake.
  task automatic load(input logic [31:0] size, input bit do_99);
    logic [7:0] b;
    int         n;
    if (do_99) wait_tx(8'h99, "timeout_tx_99");
    for (int i = 0; i < 4; i++) begin
      b = size[31-8*i -: 8];
      if (i == 3 && size == 32'd0) exp_tx_q.push_back(8'hAA);
      send_byte(b);
    end
    n = int'(size);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) exp_tx_q.push_back(8'hAA);
      send_byte(stim_bytes[i]);
      if ((i % 4) == 3 || i == n - 1) push_word(stim_words[i/4]);
    end
    @(negedge clk);
    check("after_last_byte", 64'({pm_wren, tx_valid}), (size == 32'd0) ? 64'd1 : 64'd3);
    tick();
    @(negedge clk);
    check("boot_done", 64'({boot_done, boot_done_w}), 64'd3);
    check("program_data_size", 64'(program_data_size), 64'(size));
    check("scoreboard_drained", 64'(exp_addr_q.size() + expw_addr_q.size() + exp_tx_q.size()),
          64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Size 8, data 01..08
    do_reset();
    stim_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    stim_words = '{32'h01020304, 32'h05060708};
    load(32'd8, 1'b1);

    // Size 0
    do_reset();
    load(32'd0, 1'b1);

    // Size 5 partial last word
    do_reset();
    stim_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    stim_words = '{32'hAABBCCDD, 32'hEE000000};
    load(32'd5, 1'b1);

    // Stalled transmitter with stray rx pulses
    do_reset();
    tx_ready = 1'b0;
    exp_tx_q.push_back(8'h99);
    tick();
    for (int k = 0; k < 10; k++) begin
      rx_valid = (k % 3 == 0);
      rx_data  = 8'h55;
      @(negedge clk);
      check("stall_tx", 64'({tx_valid, tx_data}), 64'h199);
      tick();
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    tick();
    @(negedge clk);
    check("stall_size", 64'(program_data_size), 64'd0);
    load(32'd0, 1'b0);

    // Reset mid-load after 3 of 8 data bytes, then full reload
    do_reset();
    wait_tx(8'h99, "timeout_tx_99_partial");
    for (int i = 0; i < 3; i++) send_byte(8'h00);
    send_byte(8'h08);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    do_reset();
    stim_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    stim_words = '{32'h01020304, 32'h05060708};
    load(32'd8, 1'b1);

    // Address wrap: 2-bit instance overwrites addr 0 with the 5th word
    do_reset();
    stim_bytes = {};
    for (int i = 1; i <= 20; i++) stim_bytes.push_back(8'(i));
    stim_words = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 32'h11121314};
    load(32'd20, 1'b1);
    check("wrap_mem0", 64'(mem_w[0]), 64'h11121314);
    check("wrap_mem3", 64'(mem_w[3]), 64'h0D0E0F10);
    check("wrap_addr_w", 64'(pm_addr_w), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
